// File: rtl/cb_segment_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cb_segment_ctrl_pkg                                                  |
// | Shared constants and state encoding for commutator-buffer blocks.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cb_segment_ctrl_pkg;

    localparam int CB_SEG_DEPTH = 8;

    localparam int CB_STATE_W = 1;
    typedef logic [CB_STATE_W-1:0] cb_state_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cb_segment_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cb_segment_ctrl_if                                                   |
// | Block/serial handshake and segment control pins of one CB segment.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface cb_segment_ctrl_if
    import cb_segment_ctrl_pkg::*;
#(
    parameter int SEG_DEPTH = CB_SEG_DEPTH,
    parameter int IDX_W     = $clog2(SEG_DEPTH)
) ();

    logic             en;
    logic             blk_valid;
    logic             blk_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [IDX_W-1:0] out_idx;
    logic             seg_sel;
    logic             seg_hold;

    modport master (
        input  en,
        input  blk_valid,
        input  out_ready,
        output blk_ready,
        output out_valid,
        output out_last,
        output out_idx,
        output seg_sel,
        output seg_hold
    );

    modport slave (
        output en,
        output blk_valid,
        output out_ready,
        input  blk_ready,
        input  out_valid,
        input  out_last,
        input  out_idx,
        input  seg_sel,
        input  seg_hold
    );

endinterface
`default_nettype wire

// File: rtl/cb_segment_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cb_segment_ctrl                                                      |
// | Load/shift sequencer for one commutator-buffer register segment.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cb_segment_ctrl
    import cb_segment_ctrl_pkg::*;
#(
    parameter int SEG_DEPTH = CB_SEG_DEPTH,
    parameter int CNT_W     = $clog2(SEG_DEPTH + 1),
    parameter int IDX_W     = $clog2(SEG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    cb_segment_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(SEG_DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    cb_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_init_done;

    cb_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_active;
    logic             w_in_shift;
    logic             w_cnt_one;
    logic             w_blk_ready;
    logic             w_out_valid;
    logic             w_blk_fire;
    logic             w_shift_fire;

    // Nothing may complete until one clock after reset release, and en=0 freezes all.
    assign w_active   = r_init_done & bus.en;
    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_cnt_one  = (r_cnt == c_CNT_ONE);

    // Last-word consumption frees the segment in the same edge, enabling gapless reload.
    assign w_blk_ready  = w_active & (~w_in_shift | (w_cnt_one & bus.out_ready));
    assign w_out_valid  = w_active & w_in_shift;
    assign w_blk_fire   = bus.blk_valid & w_blk_ready;
    assign w_shift_fire = w_out_valid & bus.out_ready;

    assign bus.blk_ready = w_blk_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_in_shift & w_cnt_one;
    assign bus.out_idx   = w_in_shift ? IDX_W'(c_CNT_FULL - r_cnt) : '0;
    assign bus.seg_sel   = w_blk_fire;
    assign bus.seg_hold  = ~(w_blk_fire | w_shift_fire);

    // A load always wins; it can coincide with a shift only on the last word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_blk_fire) begin
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = c_CNT_FULL;
        end else if (w_shift_fire) begin
            if (w_cnt_one) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cb_segment_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cb_segment_ctrl                                                   |
// | Self-checking bench: queue model of block words plus segment model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cb_segment_ctrl;
    import cb_segment_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    cb_segment_ctrl_if #(.SEG_DEPTH(DEPTH)) bus ();

    cb_segment_ctrl #(.SEG_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Segment register chain as the parent would build it; Q is stage 0.
    logic [7:0] d   [DEPTH];
    logic [7:0] seg [DEPTH];
    logic [7:0] q;
    assign q = seg[0];

    always @(posedge clk) begin
        if (!bus.seg_hold) begin
            if (bus.seg_sel) begin
                for (int i = 0; i < DEPTH; i++) seg[i] <= d[i];
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) seg[i] <= seg[i+1];
                seg[DEPTH-1] <= 8'h00;
            end
        end
    end

    // Reference: words of the current block still to be delivered, and words waiting upstream.
    logic [7:0] mq  [$];
    logic [7:0] src [$];
    bit         m_init   = 1'b0;
    bit         want_blk = 1'b0;

    function automatic bit m_active();
        return m_init && (bus.en === 1'b1);
    endfunction
    function automatic bit m_ov();
        return m_active() && (mq.size() > 0);
    endfunction
    function automatic bit m_br();
        return m_active() && (mq.size() == 0 || (mq.size() == 1 && bus.out_ready === 1'b1));
    endfunction
    function automatic logic [IDX_W-1:0] m_idx();
        return (mq.size() > 0) ? IDX_W'(DEPTH - mq.size()) : '0;
    endfunction
    function automatic bit m_last();
        return mq.size() == 1;
    endfunction

    task automatic present();
        bus.blk_valid = want_blk && (src.size() >= DEPTH);
        for (int i = 0; i < DEPTH; i++) d[i] = (src.size() > i) ? src[i] : 8'h00;
    endtask

    task automatic tick();
        bit bf;
        bit sf;
        bf = (bus.blk_valid === 1'b1) && m_br();
        sf = m_ov() && (bus.out_ready === 1'b1);
        @(posedge clk);
        if (rst_n) begin
            if (sf) void'(mq.pop_front());
            if (bf) begin
                mq.delete();
                repeat (DEPTH) mq.push_back(src.pop_front());
            end
            m_init = 1'b1;
        end
        @(negedge clk);
        present();
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.out_ready = 1'b0; want_blk = 1'b0; present();
        @(negedge clk); #1;
        n_total++;
        if ({bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold} !== 4'b0001)
            $display("FAIL reset_in got=%b exp=0001", {bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold});
        else n_pass++;
        rst_n = 1'b1; #1;
        n_total++;
        if (bus.blk_ready !== 1'b0) $display("FAIL reset_rel_ready got=%b exp=0", bus.blk_ready);
        else n_pass++;
        tick(); #1;
        n_total++;
        if ({bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold} !== 4'b0101)
            $display("FAIL reset_init got=%b exp=0101", {bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold});
        else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] got [$];
        logic [3:0] exp_hs;
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        want_blk = 1'b1; bus.out_ready = 1'b1; present();
        for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
            #1;
            exp_hs = {m_ov(), m_br(), bus.blk_valid & m_br(), !((bus.blk_valid & m_br()) | (m_ov() & bus.out_ready))};
            n_total++;
            if ({bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold} !== exp_hs)
                $display("FAIL single_hs cyc=%0d got=%b exp=%b", cyc, {bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold}, exp_hs);
            else n_pass++;
            if (m_ov()) begin
                n_total++;
                if ({q, bus.out_idx, bus.out_last} !== {mq[0], m_idx(), m_last()})
                    $display("FAIL single_data cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, q, bus.out_idx, bus.out_last, mq[0], m_idx(), m_last());
                else n_pass++;
                got.push_back(q);
            end
            tick();
        end
        #1;
        n_total++;
        if ({bus.out_valid, bus.blk_ready, bus.out_idx} !== {1'b0, 1'b1, 3'd0})
            $display("FAIL single_idle got=%b/%b/%0d exp=0/1/0", bus.out_valid, bus.blk_ready, bus.out_idx);
        else n_pass++;
        n_total++;
        if (got.size() != 8 || got[0] !== 8'd1 || got[7] !== 8'd8)
            $display("FAIL single_order got_n=%0d exp_n=8", got.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] got [$];
        logic [3:0] exp_hs;
        int         bad = 0;
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        want_blk = 1'b1; present();
        for (int cyc = 0; cyc < 80 && got.size() < 8; cyc++) begin
            bus.out_ready = (cyc % 3 == 0);
            #1;
            exp_hs = {m_ov(), m_br(), bus.blk_valid & m_br(), !((bus.blk_valid & m_br()) | (m_ov() & bus.out_ready))};
            n_total++;
            if ({bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold} !== exp_hs)
                $display("FAIL bp_hs cyc=%0d got=%b exp=%b", cyc, {bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold}, exp_hs);
            else n_pass++;
            if (m_ov()) begin
                n_total++;
                if ({q, bus.out_idx, bus.out_last} !== {mq[0], m_idx(), m_last()})
                    $display("FAIL bp_data cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, q, bus.out_idx, bus.out_last, mq[0], m_idx(), m_last());
                else n_pass++;
                if (bus.out_ready) got.push_back(q);
            end
            tick();
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i + 1)) bad++;
        n_total++;
        if (got.size() != 8 || bad != 0) $display("FAIL bp_order got_n=%0d bad=%0d exp_n=8 bad=0", got.size(), bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [$];
        logic [3:0] exp_hs;
        int         first = -1;
        int         last  = -1;
        int         bad   = 0;
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        want_blk = 1'b1; bus.out_ready = 1'b1; present();
        for (int cyc = 0; cyc < 60 && got.size() < 16; cyc++) begin
            #1;
            exp_hs = {m_ov(), m_br(), bus.blk_valid & m_br(), !((bus.blk_valid & m_br()) | (m_ov() & bus.out_ready))};
            n_total++;
            if ({bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold} !== exp_hs)
                $display("FAIL b2b_hs cyc=%0d got=%b exp=%b", cyc, {bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold}, exp_hs);
            else n_pass++;
            if (bus.out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                got.push_back(q);
            end
            tick();
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i + 1)) bad++;
        n_total++;
        if (got.size() != 16 || bad != 0) $display("FAIL b2b_order got_n=%0d bad=%0d exp_n=16 bad=0", got.size(), bad);
        else n_pass++;
        n_total++;
        if (last - first + 1 != 16) $display("FAIL b2b_gap got_span=%0d exp_span=16", last - first + 1);
        else n_pass++;
    endtask

    task automatic test_enable_freeze();
        logic [7:0] got [$];
        logic [7:0] q_frz;
        bit         reached = 1'b0;
        int         bad = 0;
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        want_blk = 1'b1; bus.out_ready = 1'b1; present();
        for (int cyc = 0; cyc < 30 && !reached; cyc++) begin
            #1;
            if (m_ov() && m_idx() == 3'd3) reached = 1'b1;
            else begin
                if (bus.out_valid === 1'b1) got.push_back(q);
                tick();
            end
        end
        q_frz = q;
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if ({bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold, q} !== {4'b0001, q_frz})
                $display("FAIL en_freeze k=%0d got=%b/%h exp=0001/%h", k, {bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold}, q, q_frz);
            else n_pass++;
            tick();
        end
        bus.en = 1'b1;
        for (int cyc = 0; cyc < 30 && got.size() < 8; cyc++) begin
            #1;
            if (m_ov()) begin
                n_total++;
                if ({bus.out_valid, q, bus.out_idx, bus.out_last} !== {1'b1, mq[0], m_idx(), m_last()})
                    $display("FAIL en_resume cyc=%0d got=%b/%h/%0d exp=1/%h/%0d", cyc, bus.out_valid, q, bus.out_idx, mq[0], m_idx());
                else n_pass++;
                got.push_back(q);
            end
            tick();
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i + 1)) bad++;
        n_total++;
        if (!reached || got.size() != 8 || bad != 0) $display("FAIL en_order got_n=%0d bad=%0d exp_n=8 bad=0", got.size(), bad);
        else n_pass++;
    endtask

    task automatic test_reset_midblock();
        logic [7:0] got [$];
        bit         reached = 1'b0;
        int         bad = 0;
        for (int i = 1; i <= 8; i++) src.push_back(8'(i));
        want_blk = 1'b1; bus.out_ready = 1'b1; present();
        for (int cyc = 0; cyc < 30 && !reached; cyc++) begin
            #1;
            if (m_ov() && m_idx() == 3'd5) reached = 1'b1;
            else tick();
        end
        rst_n = 1'b0;
        mq.delete(); m_init = 1'b0;
        #1;
        n_total++;
        if ({bus.out_valid, bus.blk_ready, bus.seg_hold} !== 3'b001)
            $display("FAIL rst_mid got=%b exp=001", {bus.out_valid, bus.blk_ready, bus.seg_hold});
        else n_pass++;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        src.delete();
        for (int i = 20; i <= 27; i++) src.push_back(8'(i));
        present();
        for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
            #1;
            n_total++;
            if ({bus.out_valid, bus.blk_ready} !== {m_ov(), m_br()})
                $display("FAIL rst_hs cyc=%0d got=%b exp=%b", cyc, {bus.out_valid, bus.blk_ready}, {m_ov(), m_br()});
            else n_pass++;
            if (m_ov()) begin
                n_total++;
                if ({q, bus.out_idx} !== {mq[0], m_idx()})
                    $display("FAIL rst_data cyc=%0d got=%h/%0d exp=%h/%0d", cyc, q, bus.out_idx, mq[0], m_idx());
                else n_pass++;
                got.push_back(q);
            end
            tick();
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(20 + i)) bad++;
        n_total++;
        if (!reached || got.size() != 8 || bad != 0) $display("FAIL rst_order got_n=%0d bad=%0d exp_n=8 bad=0", got.size(), bad);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] got [$];
        logic [7:0] sent [$];
        logic [3:0] exp_hs;
        int         bad = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            src.push_back(8'($urandom));
            sent.push_back(src[src.size() - 1]);
        end
        present();
        for (int cyc = 0; cyc < 600 && got.size() < 4 * DEPTH; cyc++) begin
            bus.out_ready = ($urandom % 4) != 0;
            bus.en        = ($urandom % 8) != 0;
            want_blk      = ($urandom % 3) != 0;
            present();
            #1;
            exp_hs = {m_ov(), m_br(), bus.blk_valid & m_br(), !((bus.blk_valid & m_br()) | (m_ov() & bus.out_ready))};
            n_total++;
            if ({bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold} !== exp_hs)
                $display("FAIL rnd_hs cyc=%0d got=%b exp=%b", cyc, {bus.out_valid, bus.blk_ready, bus.seg_sel, bus.seg_hold}, exp_hs);
            else n_pass++;
            if (m_ov()) begin
                n_total++;
                if ({q, bus.out_idx, bus.out_last} !== {mq[0], m_idx(), m_last()})
                    $display("FAIL rnd_data cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, q, bus.out_idx, bus.out_last, mq[0], m_idx(), m_last());
                else n_pass++;
                if (bus.out_ready) got.push_back(q);
            end
            tick();
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== sent[i]) bad++;
        n_total++;
        if (got.size() != 4 * DEPTH || bad != 0) $display("FAIL rnd_order got_n=%0d bad=%0d exp_n=%0d bad=0", got.size(), bad, 4 * DEPTH);
        else n_pass++;
        bus.en = 1'b1;
    endtask

    initial begin
        bus.en = 1'b1; bus.blk_valid = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) d[i] = 8'h00;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_enable_freeze();
        test_reset_midblock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
